// File: rtl/dmem_stack.sv
// dmem_stack: data memory with a downward-growing hardware stack and duplicate-request guard
module dmem_stack #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int PCW = 12,
  parameter logic [AW-1:0] SP_INIT = AW'(2**AW-1),
  parameter logic [AW-1:0] SP_LIMIT = AW'(2**AW-16)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DW-1:0]  dat_in,
  input  logic           wr_en,
  input  logic [AW-1:0]  addr,
  input  logic [PCW-1:0] prog_ctr,
  input  logic           push,
  input  logic           pop,
  output logic [DW-1:0]  dat_out,
  output logic [DW-1:0]  pop_data,
  output logic           pop_valid,
  output logic [AW-1:0]  sp,
  output logic           full,
  output logic           empty,
  output logic [1:0]     err
);
  logic [DW-1:0] core [2**AW];
  logic [PCW-1:0] last_pc;
  logic last_vld, req, conflict, acc, do_push, do_pop, we;
  logic [AW-1:0] sp_inc, wa;
  assign dat_out = core[addr];
  assign full = sp < SP_LIMIT;
  assign empty = sp == SP_INIT;
  assign sp_inc = sp + 1'b1;
  assign req = wr_en | push | pop;
  assign conflict = (wr_en & push) | (wr_en & pop) | (push & pop);
  // a request repeated from the same PC is a replay of one already accepted
  assign acc = req && !conflict && (!last_vld || prog_ctr != last_pc);
  assign do_push = acc && push && !full;
  assign do_pop = acc && pop && !empty;
  assign we = (acc && wr_en) || do_push;
  assign wa = wr_en ? addr : sp;
  always_ff @(posedge clk)
    if (!reset && we) core[wa] <= dat_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= SP_INIT;
      pop_data <= '0;
      pop_valid <= 1'b0;
      err <= 2'b00;
      last_vld <= 1'b0;
      last_pc <= '0;
    end else begin
      pop_valid <= do_pop;
      if (do_pop) pop_data <= core[sp_inc];
      sp <= do_push ? sp - 1'b1 : do_pop ? sp_inc : sp;
      if (acc) begin
        last_pc <= prog_ctr;
        last_vld <= 1'b1;
      end
      err <= err | {req && conflict, acc && ((push && full) || (pop && empty))};
    end
  end
endmodule

// File: tb/tb_dmem_stack.sv
// tb_dmem_stack: randomized scoreboard bench for dmem_stack against a behavioural model
module tb_dmem_stack;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] dat_in = '0, addr = '0, dat_out, pop_data, sp;
  logic [11:0] prog_ctr = '0;
  logic pop_valid, full, empty;
  logic [1:0] err;
  int total = 0, bad = 0;
  logic [7:0] mem [256];
  int msp = 255;
  logic [1:0] merr = 2'b00;
  bit mlv = 0;
  logic [11:0] mlpc = '0;
  logic [7:0] exp_q [$];
  bit mon_on = 0;

  dmem_stack dut (.clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en), .addr(addr),
    .prog_ctr(prog_ctr), .push(push), .pop(pop), .dat_out(dat_out), .pop_data(pop_data),
    .pop_valid(pop_valid), .sp(sp), .full(full), .empty(empty), .err(err));

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // apply one cycle of stimulus, advance the model by the behavioural rules, then check status
  task automatic step(bit w, bit pu, bit po, logic [7:0] a, logic [7:0] d, logic [11:0] pc, bit r = 0);
    bit exp_pv = 0;
    @(negedge clk);
    wr_en = w; push = pu; pop = po; addr = a; dat_in = d; prog_ctr = pc; reset = r;
    if (r) begin
      msp = 255; merr = 2'b00; mlv = 0; mlpc = '0;
    end else if (w | pu | po) begin
      if (int'(w) + int'(pu) + int'(po) > 1) merr[1] = 1'b1;
      else if (!mlv || pc != mlpc) begin
        mlv = 1; mlpc = pc;
        if (w) mem[a] = d;
        else if (pu) begin
          if (msp < 240) merr[0] = 1'b1;
          else begin mem[msp] = d; msp--; end
        end else begin
          if (msp == 255) merr[0] = 1'b1;
          else begin msp++; exp_q.push_back(mem[msp]); exp_pv = 1; end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("sp", int'(sp), msp);
    chk("full", int'(full), int'(msp < 240));
    chk("empty", int'(empty), int'(msp == 255));
    chk("err", int'(err), int'(merr));
    chk("pop_valid", int'(pop_valid), int'(exp_pv));
    chk("dat_out", int'(dat_out), int'(mem[a]));
  endtask

  always @(negedge clk)
    if (mon_on && pop_valid) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("pop_data", int'(pop_data), int'(exp_q.pop_front()));
    end

  initial begin
    logic [11:0] pc = 12'd100;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 8'h00, 8'h00, 12'd0, 1);
    mon_on = 1;
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 8'(i), 8'($urandom), pc);
      pc++;
    end
    step(0, 0, 0, 8'h00, 8'h00, 12'd0, 1);
    step(1, 0, 0, 8'h10, 8'hA5, 12'd5);
    step(0, 0, 0, 8'h10, 8'h00, 12'd5);
    chk("store_a5", int'(dat_out), 8'hA5);
    step(1, 0, 0, 8'h20, 8'd1, 12'd7);
    step(1, 0, 0, 8'h20, 8'd2, 12'd7);
    step(1, 0, 0, 8'h20, 8'd3, 12'd7);
    chk("dup_store", int'(dat_out), 1);
    step(0, 0, 0, 8'h00, 8'h00, 12'd0, 1);
    step(0, 1, 0, 8'hFF, 8'h11, 12'd1);
    step(0, 1, 0, 8'hFE, 8'h22, 12'd2);
    step(0, 0, 1, 8'h00, 8'h00, 12'd3);
    step(0, 0, 1, 8'h00, 8'h00, 12'd4);
    step(0, 0, 0, 8'h00, 8'h00, 12'd4);
    chk("sp_back", int'(sp), 8'hFF);
    step(0, 0, 0, 8'h00, 8'h00, 12'd0, 1);
    step(0, 0, 1, 8'h00, 8'h00, 12'd1);
    chk("underflow_err", int'(err), 1);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 8'hF0, 8'(i + 8'h40), 12'(i + 2));
    chk("full_17", int'(full), 1);
    step(0, 0, 0, 8'h00, 8'h00, 12'd0, 1);
    step(1, 1, 0, 8'h30, 8'h77, 12'd9);
    chk("conflict_err", int'(err), 2);
    step(0, 1, 0, 8'hFF, 8'h66, 12'd9);
    chk("push_after_conflict", int'(sp), 8'hFE);
    step(0, 1, 0, 8'hFE, 8'h55, 12'd10, 1);
    chk("reset_push_err", int'(err), 0);
    for (int n = 0; n < 3000; n++) begin
      int k = $urandom_range(0, 99);
      bit w = k < 20, pu = k >= 20 && k < 55, po = k >= 55 && k < 90;
      if (k >= 95) begin w = 1'($urandom); pu = 1'($urandom); po = 1'($urandom); end
      step(w, pu, po, 8'($urandom_range(224, 255)), 8'($urandom), 12'($urandom_range(0, 7)),
           $urandom_range(0, 199) == 0);
    end
    repeat (3) step(0, 0, 0, 8'h00, 8'h00, 12'd0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
